slot_alloc: RTL and testbench

- Parametrised one-hot slot allocator: tracks busy/free state of N = 2^IDX_W entries (ROB/TLB/MSHR-style tags) in a busy vector.
- Successor to the fixed-width N-to-2^N decoders: generic IDX_W, index-to-one-hot decode for free, one-hot-to-index priority encode for allocate, plus registered state.
- Sits beside pipeline stages that need to acquire a tag on issue and release it on retire. It offers one allocate and one free port per cycle.

---
 rtl/slot_alloc.sv | 96 +++++++++
 tb/tb_slot_alloc.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/slot_alloc.sv
// One-hot slot allocator: tracks busy/free state of 2^IDX_W tags with one
// allocate port (lowest-first or round-robin) and one free port per cycle.
module slot_alloc #(
    parameter int unsigned IDX_W   = 4,
    parameter int unsigned RR_MODE = 0
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   alloc_req,
    output logic                   alloc_gnt,
    output logic [IDX_W-1:0]       alloc_idx,
    input  logic                   free_valid,
    input  logic [IDX_W-1:0]       free_idx,
    output logic [(1<<IDX_W)-1:0]  busy_mask,
    output logic [IDX_W:0]         free_cnt,
    output logic                   full,
    output logic                   empty,
    output logic                   err_dbl_free
);

    localparam int unsigned N     = 1 << IDX_W;
    localparam int unsigned CNT_W = IDX_W + 1;

    logic [N-1:0]     r_busy;
    logic [CNT_W-1:0] r_free_cnt;
    logic             r_full;
    logic             r_empty;
    logic             r_err;
    logic [IDX_W-1:0] r_rr_ptr;

    logic             w_pick_ok;
    logic [IDX_W-1:0] w_pick_idx;
    logic [IDX_W-1:0] w_scan;
    logic             w_gnt;
    logic             w_legal_free;
    logic             w_bad_free;
    logic [N-1:0]     w_alloc_oh;
    logic [N-1:0]     w_free_oh;
    logic [N-1:0]     w_busy_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;

    // Priority search over the registered busy vector; round-robin starts just above the last grant.
    always_comb begin
        w_pick_ok  = 1'b0;
        w_pick_idx = '0;
        w_scan     = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (RR_MODE != 0) begin
                w_scan = r_rr_ptr + IDX_W'(k + 1);
            end else begin
                w_scan = IDX_W'(k);
            end
            if (!w_pick_ok && !r_busy[w_scan]) begin
                w_pick_ok  = 1'b1;
                w_pick_idx = w_scan;
            end
        end
    end

    assign w_gnt        = alloc_req & ~r_full & resetn & w_pick_ok;
    assign w_legal_free = free_valid & r_busy[free_idx];
    assign w_bad_free   = free_valid & ~r_busy[free_idx];
    assign w_alloc_oh   = w_gnt ? (N'(1) << w_pick_idx) : '0;
    assign w_free_oh    = w_legal_free ? (N'(1) << free_idx) : '0;
    assign w_busy_nxt   = (r_busy | w_alloc_oh) & ~w_free_oh;
    assign w_cnt_nxt    = r_free_cnt - CNT_W'(w_gnt) + CNT_W'(w_legal_free);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_busy     <= '0;
            r_free_cnt <= CNT_W'(N);
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_err      <= 1'b0;
            r_rr_ptr   <= '0;
        end else begin
            r_busy     <= w_busy_nxt;
            r_free_cnt <= w_cnt_nxt;
            r_full     <= (w_cnt_nxt == '0);
            r_empty    <= (w_cnt_nxt == CNT_W'(N));
            r_err      <= w_bad_free;
            if (w_gnt) begin
                r_rr_ptr <= w_pick_idx;
            end
        end
    end

    assign alloc_gnt    = w_gnt;
    assign alloc_idx    = w_gnt ? w_pick_idx : '0;
    assign busy_mask    = r_busy;
    assign free_cnt     = r_free_cnt;
    assign full         = r_full;
    assign empty        = r_empty;
    assign err_dbl_free = r_err;

endmodule

// File: tb/tb_slot_alloc.sv
// Bench for slot_alloc: lowest-first and round-robin instances share stimulus;
// a scoreboard of expected per-cycle state and grant indices is checked by a monitor.
module tb_slot_alloc;

    localparam int IDX_W = 4;
    localparam int N     = 16;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        alloc_req = 1'b0;
    logic        free_valid = 1'b0;
    logic [3:0]  free_idx = '0;

    logic        gnt   [2];
    logic [3:0]  aidx  [2];
    logic [15:0] busy  [2];
    logic [4:0]  cnt   [2];
    logic        full  [2];
    logic        empty [2];
    logic        err   [2];

    always #5 clk = ~clk;

    slot_alloc #(.IDX_W(IDX_W), .RR_MODE(0)) u_lo (
        .clk(clk), .resetn(resetn), .alloc_req(alloc_req), .alloc_gnt(gnt[0]),
        .alloc_idx(aidx[0]), .free_valid(free_valid), .free_idx(free_idx),
        .busy_mask(busy[0]), .free_cnt(cnt[0]), .full(full[0]), .empty(empty[0]),
        .err_dbl_free(err[0]));

    slot_alloc #(.IDX_W(IDX_W), .RR_MODE(1)) u_rr (
        .clk(clk), .resetn(resetn), .alloc_req(alloc_req), .alloc_gnt(gnt[1]),
        .alloc_idx(aidx[1]), .free_valid(free_valid), .free_idx(free_idx),
        .busy_mask(busy[1]), .free_cnt(cnt[1]), .full(full[1]), .empty(empty[1]),
        .err_dbl_free(err[1]));

    typedef struct {
        bit          gnt;
        logic [15:0] busy;
        int          cnt;
        bit          full;
        bit          empty;
        bit          err;
    } rec_t;

    rec_t sq0[$], sq1[$];
    int   aq0[$], aq1[$];

    int nchk = 0;
    int nerr = 0;
    bit mon_en = 1'b0;

    // Reference model: slot set as a bit array, pointer as an int.
    bit mbusy [2][N];
    int mptr  [2];
    bit merr  [2];

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_mask(input int k);
        logic [15:0] m = '0;
        for (int i = 0; i < N; i++) m[i] = mbusy[k][i];
        return m;
    endfunction

    function automatic int model_free(input int k);
        int c = 0;
        for (int i = 0; i < N; i++) if (!mbusy[k][i]) c++;
        return c;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < N; i++) mbusy[k][i] = 1'b0;
            mptr[k] = 0;
            merr[k] = 1'b0;
        end
    endtask

    // Predict this cycle's visible outputs, queue them, then advance the model.
    task automatic model_cycle(input int k, input bit req, input bit fv, input int fi);
        rec_t r;
        int   fc, start, pick;
        bit   legal;
        fc      = model_free(k);
        r.gnt   = req && (fc > 0);
        r.busy  = model_mask(k);
        r.cnt   = fc;
        r.full  = (fc == 0);
        r.empty = (fc == N);
        r.err   = merr[k];
        start   = (k == 1) ? mptr[k] + 1 : 0;
        pick    = 0;
        for (int j = N - 1; j >= 0; j--) if (!mbusy[k][(start + j) % N]) pick = (start + j) % N;
        if (k == 0) sq0.push_back(r); else sq1.push_back(r);
        if (r.gnt) begin
            if (k == 0) aq0.push_back(pick); else aq1.push_back(pick);
        end
        legal   = fv && mbusy[k][fi];
        merr[k] = fv && !mbusy[k][fi];
        if (legal) mbusy[k][fi] = 1'b0;
        if (r.gnt) begin
            mbusy[k][pick] = 1'b1;
            mptr[k] = pick;
        end
    endtask

    task automatic step(input bit req, input bit fv, input int fi);
        alloc_req  = req;
        free_valid = fv;
        free_idx   = 4'(fi);
        model_cycle(0, req, fv, fi);
        model_cycle(1, req, fv, fi);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        alloc_req = 1'b0; free_valid = 1'b0; free_idx = '0;
        resetn = 1'b0;
        model_reset();
        sq0.delete(); sq1.delete(); aq0.delete(); aq1.delete();
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic check_inst(input int k, input rec_t r, input bit has_idx, input int ei);
        string p = (k == 0) ? "lo" : "rr";
        cmp({p, " gnt"},   32'(gnt[k]),   32'(r.gnt));
        cmp({p, " busy"},  32'(busy[k]),  32'(r.busy));
        cmp({p, " cnt"},   32'(cnt[k]),   32'(r.cnt));
        cmp({p, " full"},  32'(full[k]),  32'(r.full));
        cmp({p, " empty"}, 32'(empty[k]), 32'(r.empty));
        cmp({p, " err"},   32'(err[k]),   32'(r.err));
        if (gnt[k]) begin
            if (!has_idx) begin
                nchk++; nerr++;
                $display("FAIL %s unexpected grant: got idx %0d expected none", p, aidx[k]);
            end else cmp({p, " idx"}, 32'(aidx[k]), 32'(ei));
        end else cmp({p, " idx_zero"}, 32'(aidx[k]), 32'd0);
    endtask

    // Monitor: pops one state record per instance each cycle and a grant index whenever a grant shows.
    always @(negedge clk) begin
        rec_t r;
        int   ei;
        bit   has;
        if (mon_en) begin
            if (sq0.size() == 0 || sq1.size() == 0) begin
                nchk++; nerr++;
                $display("FAIL scoreboard underflow: got empty queue expected a record");
            end else begin
                r = sq0.pop_front();
                has = (gnt[0] && aq0.size() > 0);
                ei = has ? aq0.pop_front() : 0;
                check_inst(0, r, has, ei);
                r = sq1.pop_front();
                has = (gnt[1] && aq1.size() > 0);
                ei = has ? aq1.pop_front() : 0;
                check_inst(1, r, has, ei);
            end
        end
    end

    initial begin
        // Reset values, with a request held during reset
        resetn = 1'b0;
        alloc_req = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        cmp("reset busy", 32'(busy[0]), 32'h0);
        cmp("reset cnt", 32'(cnt[0]), 32'd16);
        cmp("reset empty", 32'(empty[0]), 32'd1);
        cmp("reset full", 32'(full[0]), 32'd0);
        cmp("reset gnt", 32'(gnt[0]), 32'd0);
        do_reset();

        // Fill, overflow request, free 5, realloc, legal free, double free
        for (int i = 0; i < N; i++) step(1, 0, 0);
        cmp("fill busy", 32'(busy[0]), 32'hFFFF);
        cmp("fill cnt", 32'(cnt[0]), 32'd0);
        cmp("fill full", 32'(full[0]), 32'd1);
        step(1, 0, 0);
        step(0, 1, 5);
        cmp("free5 busy", 32'(busy[0]), 32'hFFDF);
        cmp("free5 cnt", 32'(cnt[0]), 32'd1);
        cmp("free5 full", 32'(full[0]), 32'd0);
        step(1, 0, 0);
        cmp("realloc busy", 32'(busy[0]), 32'hFFFF);
        step(0, 1, 5);
        step(0, 1, 5);
        cmp("dbl err", 32'(err[0]), 32'd1);
        cmp("dbl cnt", 32'(cnt[0]), 32'd1);
        step(0, 0, 0);
        cmp("dbl err clear", 32'(err[0]), 32'd0);
        // Full plus request plus legal free: no grant now, freed slot granted next
        step(1, 0, 0);
        step(1, 1, 7);
        step(1, 0, 0);
        cmp("full-free busy", 32'(busy[0]), 32'hFFFF);

        // Simultaneous alloc and free
        do_reset();
        step(1, 0, 0);
        step(1, 0, 0);
        cmp("sim pre busy", 32'(busy[0]), 32'h0003);
        step(1, 1, 0);
        cmp("sim busy", 32'(busy[0]), 32'h0006);
        cmp("sim cnt", 32'(cnt[0]), 32'd14);

        // Round-robin: free an early grant, next grant continues past the pointer
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 0, 0);
        step(0, 1, 1);
        step(1, 0, 0);
        for (int i = 0; i < 14; i++) step(1, (i == 5), 2);

        // Randomised traffic
        do_reset();
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50, int'($urandom_range(0, 15)));

        // Mid-cycle asynchronous reset with busy_mask 0x00F0 on the lowest-first instance
        do_reset();
        for (int i = 0; i < 8; i++) step(1, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, i);
        step(0, 0, 0);
        cmp("pre-areset busy", 32'(busy[0]), 32'h00F0);
        mon_en = 1'b0;
        alloc_req = 1'b1;
        #2;
        resetn = 1'b0;
        #1;
        cmp("areset busy", 32'(busy[0]), 32'h0);
        cmp("areset cnt", 32'(cnt[0]), 32'd16);
        cmp("areset empty", 32'(empty[0]), 32'd1);
        cmp("areset full", 32'(full[0]), 32'd0);
        cmp("areset err", 32'(err[0]), 32'd0);
        cmp("areset gnt", 32'(gnt[0]), 32'd0);
        cmp("areset rr busy", 32'(busy[1]), 32'h0);

        cmp("leftover lo grants", 32'(aq0.size()), 32'd0);
        cmp("leftover rr grants", 32'(aq1.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
